uart_tx_buf: RTL

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter: byte FIFO feeding an 8N1 serializer
module uart_tx_buf #(
   parameter int BAUD_CNT_MAX = 5,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       full,
   output logic       ovf,
   output logic       busy,
   output logic       tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BAUD_CNT_MAX);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BW-1:0]   r_baud;
   logic [BW-1:0]   w_baud_nxt;
   logic [2:0]      r_bit;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      r_shift;
   logic            r_tx;
   logic            w_tx_nxt;
   logic            r_ovf;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            w_full;
   logic            w_wr;
   logic            w_pop;
   logic            w_baud_last;
   logic            w_have_data;

   // full comes from the registered count only, so a pop never frees room for a same-cycle write
   assign w_full      = (r_count == DEPTH_CNT);
   assign w_wr        = pi_flag & ~w_full;
   assign w_have_data = (r_count != '0);
   assign w_baud_last = (r_baud == BAUD_LAST);

   assign full = w_full;
   assign ovf  = r_ovf;
   assign busy = (r_state != S_IDLE);
   assign tx   = r_tx;

   // FSM next state, baud/bit counters, pop request and the next line level
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud + BW'(1);
      w_bit_nxt   = r_bit;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (w_have_data) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_last) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_baud_last) begin
               w_baud_nxt = '0;
               // back-to-back frames: reload straight into START with no idle gap
               if (w_have_data) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_baud_nxt  = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
      // line level is decided from where the FSM is going so tx can be a plain register
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = r_shift[w_bit_nxt];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // FSM state, counters, shift register and the registered line output
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
         end
      end
   end

   // FIFO pointers, occupancy and the dropped-write pulse
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_ovf <= pi_flag & w_full;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the count says empty
   always_ff @(posedge sys_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= pi_data;
      end
   end

endmodule
